// File: rtl/fc_argmax.sv
// Fully-connected 4x4 classifier with argmax over the four class scores.
// Loads 16 signed weights and collects 4 pooled features per frame, then runs a 16-cycle serial MAC.
module fc_argmax (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w_valid,
  input  logic [15:0] w_data,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        busy,
  output logic        out_valid,
  output logic [1:0]  out_class,
  output logic [15:0] out_score,
  output logic        out_sat
);

  localparam int unsigned DW = 16;
  localparam int unsigned PW = 32;
  localparam int unsigned AW = 36;
  localparam int unsigned NW = 16;
  localparam int unsigned NX = 4;

  localparam logic signed [AW-1:0] SMAX = AW'(32767);
  localparam logic signed [AW-1:0] SMIN = AW'(-32768);

  typedef enum logic [1:0] {IDLE, COLLECT, CALC, OUT} state_e;

  state_e state_q, state_d;

  logic [3:0]                 wptr_q;
  logic                       w_loaded_q;
  logic signed [DW-1:0]       w_mem [NW];
  logic signed [DW-1:0]       x_mem [NX];
  logic [1:0]                 xcnt_q, xcnt_d;
  logic [3:0]                 k_q;
  logic signed [AW-1:0]       acc_q;
  logic                       sat_q;
  logic signed [DW-1:0]       best_score_q;
  logic [1:0]                 best_class_q;

  logic                       busy_q, busy_d;
  logic                       out_valid_q, out_valid_d;
  logic [1:0]                 out_class_q;
  logic signed [DW-1:0]       out_score_q;
  logic                       out_sat_q;

  logic                       w_we_c, x_we_c, calc_enter_c;
  logic signed [DW-1:0]       w_sel_c, x_sel_c;
  logic signed [PW-1:0]       prod_c;
  logic signed [AW-1:0]       acc_sum_c;
  logic                       hi_c, lo_c, class_end_c, new_best_c;
  logic signed [DW-1:0]       score_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && w_loaded_q) state_d = COLLECT;
      COLLECT: begin
        if (!in_valid)              state_d = IDLE;
        else if (xcnt_q == 2'd3)    state_d = CALC;
      end
      CALC:    if (k_q == 4'd15)    state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy_d       = 1'b0;
    out_valid_d  = 1'b0;
    w_we_c       = 1'b0;
    x_we_c       = 1'b0;
    calc_enter_c = 1'b0;
    xcnt_d       = 2'd0;
    busy_d       = (state_d == CALC) || (state_d == OUT);
    out_valid_d  = (state_q == OUT);
    w_we_c       = w_valid && !busy_q;
    x_we_c       = in_valid && (((state_q == IDLE) && w_loaded_q) || (state_q == COLLECT));
    calc_enter_c = (state_q != CALC) && (state_d == CALC);
    if (state_d == COLLECT) xcnt_d = xcnt_q + 2'd1;
  end

  // MAC datapath: step k uses W[k] and x[k%4]; the class restarts every 4 steps
  always_comb begin
    w_sel_c     = w_mem[k_q];
    x_sel_c     = x_mem[k_q[1:0]];
    prod_c      = PW'(w_sel_c) * PW'(x_sel_c);
    acc_sum_c   = ((k_q[1:0] == 2'd0) ? '0 : acc_q) + AW'(prod_c);
    hi_c        = acc_sum_c > SMAX;
    lo_c        = acc_sum_c < SMIN;
    score_c     = acc_sum_c[DW-1:0];
    if (hi_c) score_c = 16'sh7FFF;
    if (lo_c) score_c = 16'sh8000;
    class_end_c = (state_q == CALC) && (k_q[1:0] == 2'd3);
    new_best_c  = (k_q[3:2] == 2'd0) || (score_c > best_score_q);
  end

  // Weight pointer and loaded flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= 4'd0;
      w_loaded_q <= 1'b0;
    end else if (w_we_c) begin
      wptr_q <= wptr_q + 4'd1;
      if (wptr_q == 4'd15) w_loaded_q <= 1'b1;
    end
  end

  // Storage arrays carry no reset
  always_ff @(posedge clk) begin
    if (w_we_c) w_mem[wptr_q] <= w_data;
    if (x_we_c) x_mem[xcnt_q] <= in_data;
  end

  // Sequencing, accumulator and running argmax
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xcnt_q       <= 2'd0;
      k_q          <= 4'd0;
      acc_q        <= '0;
      sat_q        <= 1'b0;
      best_score_q <= '0;
      best_class_q <= 2'd0;
    end else begin
      xcnt_q <= xcnt_d;
      k_q    <= (state_q == CALC) ? k_q + 4'd1 : 4'd0;
      if (calc_enter_c) begin
        acc_q <= '0;
        sat_q <= 1'b0;
      end else if (state_q == CALC) begin
        acc_q <= acc_sum_c;
        if (class_end_c) begin
          sat_q <= sat_q | hi_c | lo_c;
          if (new_best_c) begin
            best_score_q <= score_c;
            best_class_q <= k_q[3:2];
          end
        end
      end
    end
  end

  // Registered outputs, held between result strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_class_q <= 2'd0;
      out_score_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      if (out_valid_d) begin
        out_class_q <= best_class_q;
        out_score_q <= best_score_q;
        out_sat_q   <= sat_q;
      end
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_score = out_score_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Self-checking bench for fc_argmax: behavioural frame/weight model with per-cycle compare,
// directed literal scenarios, then randomized traffic.
module tb_fc_argmax;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_valid = 1'b0;
  logic [15:0] w_data = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        busy, out_valid, out_sat;
  logic [1:0]  out_class;
  logic [15:0] out_score;

  always #5 clk = ~clk;

  fc_argmax dut (
    .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_data(w_data),
    .in_valid(in_valid), .in_data(in_data), .busy(busy), .out_valid(out_valid),
    .out_class(out_class), .out_score(out_score), .out_sat(out_sat)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic signed [15:0] mw [16];
  int  m_wptr, m_n, m_cnt, m_class, m_score, p_class, p_score;
  bit  m_loaded, m_busy, m_ov, m_sat, p_sat;
  int  mx [4];

  function automatic void compute_frame();
    longint s;
    int sc;
    bit sat;
    sat = 0;
    for (int c = 0; c < 4; c++) begin
      s = 0;
      for (int j = 0; j < 4; j++) s += longint'(mw[c*4+j]) * longint'(mx[j]);
      if (s > 32767)       begin sc = 32767;  sat = 1; end
      else if (s < -32768) begin sc = -32768; sat = 1; end
      else                 sc = int'(s);
      if (c == 0 || sc > p_score) begin p_score = sc; p_class = c; end
    end
    p_sat = sat;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit busy_pre, loaded_pre;
    if (!rst_n) begin
      m_wptr = 0; m_n = 0; m_cnt = 0; m_loaded = 0; m_busy = 0; m_ov = 0;
      m_class = 0; m_score = 0; m_sat = 0;
    end else begin
      busy_pre   = m_busy;
      loaded_pre = m_loaded;
      m_ov = 0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0; m_ov = 1;
          m_class = p_class; m_score = p_score; m_sat = p_sat;
        end
      end
      if (w_valid && !busy_pre) begin
        mw[m_wptr] = w_data;
        m_wptr = (m_wptr + 1) % 16;
        if (m_wptr == 0) m_loaded = 1;
      end
      if (!busy_pre) begin
        if (in_valid && (m_n > 0 || loaded_pre)) begin
          mx[m_n] = int'($signed(in_data));
          m_n++;
          if (m_n == 4) begin
            compute_frame();
            m_n = 0; m_busy = 1; m_cnt = 17;
          end
        end else if (!in_valid) begin
          m_n = 0;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("busy",      longint'(busy),      longint'(m_busy));
      check("out_valid", longint'(out_valid), longint'(m_ov));
      check("out_class", longint'(out_class), longint'(m_class));
      check("out_score", longint'($signed(out_score)), longint'(m_score));
      check("out_sat",   longint'(out_sat),   longint'(m_sat));
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [15:0] wset [16];

  task automatic set_identity();
    for (int i = 0; i < 16; i++) wset[i] = ((i / 4) == (i % 4)) ? 16'd1 : 16'd0;
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 16; i++) wset[i] = v;
  endtask

  task automatic load_range(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk); w_valid = 1'b1; w_data = wset[i];
    end
    @(negedge clk); w_valid = 1'b0;
  endtask

  task automatic send_frame(input int a, input int b, input int c, input int d);
    int v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 16'(v[j]);
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  // Called right after send_frame: the next rising edge is the first after x[3] capture
  task automatic expect_result(input string name, input int ec, input int es, input int esat);
    int n;
    bit got;
    n = 0; got = 0;
    while (n < 30 && !got) begin
      @(posedge clk); #1; n++;
      if (out_valid) got = 1;
    end
    check({name, " latency"}, got ? n : -1, 17);
    if (got) begin
      check({name, " class"}, longint'(out_class), ec);
      check({name, " score"}, longint'($signed(out_score)), es);
      check({name, " sat"},   longint'(out_sat), esat);
      @(posedge clk); #1;
      check({name, " pulse width"}, longint'(out_valid), 0);
    end
  endtask

  task automatic expect_none(input string name, input int cycles);
    bit seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1;
    end
    check({name, " no activity"}, longint'(seen), 0);
  endtask

  task automatic do_reset();
    w_valid = 1'b0; in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_word();
    case ($urandom % 5)
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'(int'($urandom_range(0, 15)) - 8);
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    do_reset();
    check("reset busy",      longint'(busy), 0);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset out_class", longint'(out_class), 0);
    check("reset out_score", longint'(out_score), 0);
    check("reset out_sat",   longint'(out_sat), 0);

    // 15 weights only: frame must be ignored
    set_identity();
    load_range(0, 14);
    send_frame(5, -3, 9, 2);
    expect_none("15 weights", 25);
    load_range(15, 15);
    send_frame(5, -3, 9, 2);
    expect_result("identity", 2, 9, 0);

    set_all(16'd1);
    load_range(0, 15);
    send_frame(1, 1, 1, 1);
    expect_result("ones tie", 0, 4, 0);

    set_all(16'hFFFF);
    load_range(0, 15);
    send_frame(1, 1, 1, 1);
    expect_result("minus ones", 0, -4, 0);

    set_all(16'h7FFF);
    load_range(0, 15);
    send_frame(32767, 32767, 32767, 32767);
    expect_result("pos sat", 0, 32767, 1);

    set_all(16'h8000);
    load_range(0, 15);
    send_frame(32767, 32767, 32767, 32767);
    expect_result("neg sat", 0, -32768, 1);

    // Aborted frame followed by a clean one
    set_identity();
    load_range(0, 15);
    @(negedge clk); in_valid = 1'b1; in_data = 16'd7;
    @(negedge clk); in_data = 16'd8;
    @(negedge clk); in_valid = 1'b0;
    expect_none("abort", 20);
    send_frame(-4, 6, 1, -20);
    expect_result("after abort", 1, 6, 0);

    // Asynchronous reset in the middle of CALC
    send_frame(5, -3, 9, 2);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midcalc busy",      longint'(busy), 0);
    check("midcalc out_valid", longint'(out_valid), 0);
    check("midcalc out_class", longint'(out_class), 0);
    check("midcalc out_score", longint'(out_score), 0);
    check("midcalc out_sat",   longint'(out_sat), 0);
    @(negedge clk); rst_n = 1'b1;
    send_frame(5, -3, 9, 2);
    expect_none("no reload", 25);

    // Randomized traffic, one reset in the middle
    for (int i = 0; i < 16; i++) wset[i] = rand_word();
    load_range(0, 15);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc == 2000) begin
        do_reset();
        for (int i = 0; i < 16; i++) wset[i] = rand_word();
        load_range(0, 15);
      end
      @(negedge clk);
      w_valid  = ($urandom % 7) == 0;
      w_data   = rand_word();
      in_valid = ($urandom % 10) < 8;
      in_data  = rand_word();
    end
    @(negedge clk); w_valid = 1'b0; in_valid = 1'b0;
    repeat (25) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fc_argmax.md
FC_ARGMAX -- requirements
Module: fc_argmax

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: w_valid  input  1  weight word strobe.
REQ-004 SHALL have port: w_data  input  16  signed weight word, row-major W[c*4+j].
REQ-005 SHALL have port: in_valid  input  1  pooled-feature strobe, connected to the CNN stage's out_valid.
REQ-006 SHALL have port: in_data  input  16  signed pooled feature x[j], connected to the CNN stage's out_data.
REQ-007 SHALL have port: busy  output  1  high in CALC and OUT.
REQ-008 SHALL have port: out_valid  output  1  one-cycle result strobe.
REQ-009 SHALL have port: out_class  output  2  argmax class index 0..3.
REQ-010 SHALL have port: out_score  output  16  signed saturated score of the winning class.
REQ-011 SHALL have port: out_sat  output  1  high if any of the 4 class scores saturated in this frame.

Function
REQ-012 SHALL hold a 4x4 signed 16-bit weight array; each w_valid word is written at index wptr; wptr increments and wraps 15->0.
REQ-013 SHALL set w_loaded after the 16th weight word since reset; w_loaded stays 1 until reset.
REQ-014 SHALL ignore w_valid while busy=1 (no write, no wptr change).
REQ-015 SHALL implement states IDLE, COLLECT, CALC, OUT.
REQ-016 IDLE->COLLECT when in_valid=1 and w_loaded=1; that sample is stored as x[0]. With w_loaded=0, in_valid is ignored.
REQ-017 COLLECT: each in_valid=1 cycle stores the next x[j]; after x[3] is stored, go to CALC.
REQ-018 COLLECT: in_valid=0 before x[3] aborts the frame: return to IDLE, discard samples, no output.
REQ-019 CALC: exactly 16 cycles; cycle k applies acc += W[(k/4)*4 + k%4] * x[k%4], with a 36-bit signed accumulator cleared at the start of each class.
REQ-020 At the end of each class, score SHALL saturate to 16 bits: >32767 -> 32767, <-32768 -> -32768; any clamp sets the frame sat flag.
REQ-021 Argmax SHALL use signed compare with strict greater; ties keep the lower class index; class 0 initialises the best.
REQ-022 OUT: one cycle; then return to IDLE.
REQ-023 out_valid SHALL pulse for exactly 1 cycle, 17 clocks after the edge that captures x[3].
REQ-024 out_class, out_score and out_sat SHALL be valid while out_valid=1, and hold their values until the next out_valid.
REQ-025 SHALL ignore in_valid during CALC and OUT; a new frame may start in the cycle after OUT.
REQ-026 sat flag and accumulator SHALL clear when entering CALC.

Reset
REQ-027 On rst_n=0, asynchronously: state=IDLE, wptr=0, w_loaded=0, busy=0, out_valid=0, out_class=0, out_score=0, out_sat=0, accumulator and sat flag cleared; weight and x arrays need no reset.
REQ-028 Reset asserted mid-frame or mid-CALC SHALL abort the frame without an out_valid pulse; weights SHALL be reloaded before the next frame.

Verification
REQ-029 Identity weights (W[c*4+j]=1 when c==j, else 0), frame 5,-3,9,2 -> one out_valid pulse 17 clocks after x[3], out_class=2, out_score=9, out_sat=0.
REQ-030 All weights 1, frame 1,1,1,1 -> out_class=0 (tie rule), out_score=4; all weights -1 with the same frame -> out_class=0, out_score=-4.
REQ-031 All weights 32767, frame 32767 x4 -> out_score=32767, out_sat=1; all weights -32768, frame 32767 x4 -> out_score=-32768, out_sat=1.
REQ-032 Only 15 weights loaded, then a frame -> no busy, no out_valid; after the 16th weight, a frame -> normal result.
REQ-033 in_valid dropped after 2 samples -> no out_valid; the next contiguous 4-sample frame produces a correct result.
REQ-034 rst_n pulsed at CALC cycle 8 -> out_valid never rises, all outputs 0; a frame sent after reset with no reload is ignored.
